// File: rtl/regfile_multiport.sv
// Multiport integer register file.
// Reads are combinational on NREAD ports and there is one synchronous write port.
// Reset does not clear the storage in one cycle. It starts a sweep that
// initialises one entry per clock, and busy stays high until the sweep is done.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int INIT_IDX = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_data,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       write_data,
  input  logic                  RegWrite,
  output logic                  busy
);

  typedef enum logic {INIT, READY} state_t;

  // One extra bit lets "address >= NREGS" work even when NREGS is a power of two.
  localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [XLEN-1:0] entry_reg [NREGS];
  logic [XLEN-1:0] init_value;
  logic            wr_legal;

  // State and sweep index register. Reset always restarts the sweep at entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= INIT;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  // Next state: step through every entry, then settle in READY.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      INIT: begin
        idx_next = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = READY;
        end
      end
      READY: begin
        state_next = READY;
      end
      default: begin
        state_next = INIT;
      end
    endcase
  end

  // Busy covers the reset cycle itself as well as the whole sweep.
  assign busy = (state_reg == INIT) || reset;

  // Sweep value: the entry index zero-extended to XLEN, or all zeros.
  always_comb begin
    init_value = '0;
    if (INIT_IDX != 0) begin
      init_value[AW-1:0] = idx_reg;
    end
  end

  // A write takes effect only when ready, in range, and not aimed at a hardwired zero.
  assign wr_legal = RegWrite && !busy && ({1'b0, rd} < NREGS_W) &&
                    !((ZERO_REG != 0) && (rd == '0));

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_entry
      // Each entry is loaded by the sweep or by a legal write. It keeps its value during reset.
      always_ff @(posedge clk) begin
        if (!reset) begin
          if (state_reg == INIT && idx_reg == AW'(gi)) begin
            entry_reg[gi] <= init_value;
          end else if (wr_legal && rd == AW'(gi)) begin
            entry_reg[gi] <= write_data;
          end
        end
      end
    end

    for (gi = 0; gi < NREAD; gi++) begin : g_read
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] rd_val;

      assign addr = rs_addr[gi*AW +: AW];

      // Read mux: zero while busy, for the zero register, or out of range; otherwise bypass or stored value.
      always_comb begin
        rd_val = '0;
        if (busy) begin
          rd_val = '0;
        end else if ((ZERO_REG != 0) && addr == '0) begin
          rd_val = '0;
        end else if ({1'b0, addr} >= NREGS_W) begin
          rd_val = '0;
        end else if ((BYPASS != 0) && wr_legal && rd == addr) begin
          rd_val = write_data;
        end else begin
          rd_val = entry_reg[addr];
        end
      end

      assign rs_data[gi*XLEN +: XLEN] = rd_val;
    end
  endgenerate

endmodule
